// File: rtl/riscv_data_mem_responder.sv
//-----------------------------------------------------------------------------
// riscv_data_mem_responder
//
// Single-port data memory that answers the core's data-side req/gnt/rvalid
// bus. Grant wait states and response latency are set by parameters, which
// lets LSU stall paths be exercised. Also provides a backdoor word-write port
// and free-running (wrapping) load/store counters.
//
// Parameters
//   MEM_WORDS   number of 32-bit words (power of two, >= 4)
//   GNT_WAIT    cycles a request is held before it is granted (0..15)
//   RVALID_LAT  cycles from the grant edge to data_rvalid_o (1..8)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   data_req_i        request valid, held stable until granted
//   data_addr_i       34-bit physical byte address
//   data_we_i         1 = store, 0 = load
//   data_be_i         byte-lane enables for stores
//   data_wdata_i      lane-aligned store data
//   data_size_i       access size (informational only)
//   data_gnt_o        request accepted this cycle (combinational)
//   data_rvalid_o     one response pulse per granted request, in order
//   data_rdata_o      load data (0 for stores, errors and idle cycles)
//   data_err_o        address out of range, qualified by data_rvalid_o
//   dbg_we_i          backdoor whole-word write
//   dbg_addr_i        backdoor word index
//   dbg_wdata_i       backdoor write data
//   rd_count_o        granted loads since reset
//   wr_count_o        granted stores since reset
//-----------------------------------------------------------------------------
module riscv_data_mem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned GNT_WAIT   = 0,
    parameter int unsigned RVALID_LAT = 1,
    localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_req_i,
    input  logic [33:0]   data_addr_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_wdata_i,
    input  logic [1:0]    data_size_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
    input  logic          dbg_we_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [31:0]   dbg_wdata_i,
    output logic [15:0]   rd_count_o,
    output logic [15:0]   wr_count_o
);

    localparam logic [3:0]  GNT_WAIT_C = 4'(GNT_WAIT);
    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic          addr_err;
    logic          store_hit;
    logic          load_hit;
    logic [31:0]   rd_word;

    logic          pipe_valid [RVALID_LAT];
    logic [31:0]   pipe_rdata [RVALID_LAT];
    logic          pipe_err   [RVALID_LAT];

    logic [15:0]   rd_count_q, wr_count_q;

    // Size and byte offset carry no decode information here.
    logic unused_bits;
    assign unused_bits = ^{data_size_i, data_addr_i[1:0]};

    //-------------------------------------------------------------------------
    // Grant and decode
    //-------------------------------------------------------------------------
    assign data_gnt_o = data_req_i & ~rst & (wait_cnt_q == GNT_WAIT_C);
    assign word_idx   = data_addr_i[AW+1:2];
    // Full-width compare so that any set bit above the array range errors.
    assign addr_err   = (data_addr_i >= ADDR_LIMIT);
    assign store_hit  = data_gnt_o & data_we_i & ~addr_err;
    assign load_hit   = data_gnt_o & ~data_we_i & ~addr_err;
    assign rd_word    = load_hit ? mem[word_idx] : '0;

    //-------------------------------------------------------------------------
    // Grant FSM
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (data_req_i && !data_gnt_o) begin
                    state_d    = WAIT;
                    wait_cnt_d = 4'd1;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                // A dropped request restarts the wait from scratch.
                if (!data_req_i || data_gnt_o) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Memory array: bus store wins over a same-word backdoor write
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (dbg_we_i && !(store_hit && (dbg_addr_i == word_idx))) begin
            mem[dbg_addr_i] <= dbg_wdata_i;
        end
        if (store_hit) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Response pipeline; data fields are zeroed on idle slots so the outputs
    // read 0 whenever rvalid is low
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RVALID_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_rdata[i] <= '0;
                pipe_err[i]   <= 1'b0;
            end
        end else begin
            pipe_valid[0] <= data_gnt_o;
            pipe_rdata[0] <= rd_word;
            pipe_err[0]   <= data_gnt_o & addr_err;
            for (int unsigned i = 1; i < RVALID_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_valid[RVALID_LAT-1];
    assign data_rdata_o  = pipe_rdata[RVALID_LAT-1];
    assign data_err_o    = pipe_err[RVALID_LAT-1];

    //-------------------------------------------------------------------------
    // Access counters (error accesses included)
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (data_gnt_o) begin
            if (data_we_i) begin
                wr_count_q <= wr_count_q + 16'd1;
            end else begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;

    // The initiator must hold its request until it is granted.
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state_q == WAIT) |-> data_req_i);

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
//-----------------------------------------------------------------------------
// Bench for riscv_data_mem_responder. Two instances with different grant
// wait / response latency settings are driven one at a time. Each issued
// request pushes its expected response (unit, due cycle, rdata, err) into a
// scoreboard queue; an independent monitor pops and compares on every rvalid.
//-----------------------------------------------------------------------------
module tb_riscv_data_mem_responder;

    localparam int MW   = 16;
    localparam int AWB  = 4;
    localparam int GW0  = 0;
    localparam int LAT0 = 3;
    localparam int GW1  = 3;
    localparam int LAT1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           req       [2];
    logic [33:0]    addr      [2];
    logic           we        [2];
    logic [3:0]     be        [2];
    logic [31:0]    wdata     [2];
    logic [1:0]     size      [2];
    logic           gnt       [2];
    logic           rvalid    [2];
    logic [31:0]    rdata     [2];
    logic           err       [2];
    logic           dbg_we    [2];
    logic [AWB-1:0] dbg_addr  [2];
    logic [31:0]    dbg_wdata [2];
    logic [15:0]    rdc       [2];
    logic [15:0]    wrc       [2];

    riscv_data_mem_responder #(.MEM_WORDS(MW), .GNT_WAIT(GW0), .RVALID_LAT(LAT0)) u0 (
        .clk(clk), .rst(rst),
        .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_wdata_i(wdata[0]), .data_size_i(size[0]),
        .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
        .data_err_o(err[0]), .dbg_we_i(dbg_we[0]), .dbg_addr_i(dbg_addr[0]),
        .dbg_wdata_i(dbg_wdata[0]), .rd_count_o(rdc[0]), .wr_count_o(wrc[0])
    );

    riscv_data_mem_responder #(.MEM_WORDS(MW), .GNT_WAIT(GW1), .RVALID_LAT(LAT1)) u1 (
        .clk(clk), .rst(rst),
        .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_wdata_i(wdata[1]), .data_size_i(size[1]),
        .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
        .data_err_o(err[1]), .dbg_we_i(dbg_we[1]), .dbg_addr_i(dbg_addr[1]),
        .dbg_wdata_i(dbg_wdata[1]), .rd_count_o(rdc[1]), .wr_count_o(wrc[1])
    );

    typedef struct {
        int          unit;
        longint      due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model [2][MW];
    logic [15:0] rd_m [2];
    logic [15:0] wr_m [2];
    longint      cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gw_of(input int u);
        return (u == 0) ? GW0 : GW1;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rvalid[u] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: unit %0d rvalid=1 with nothing outstanding (cycle %0d)", u, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("resp_unit", u, e.unit);
                    check("resp_cycle", cyc, e.due);
                    check("resp_rdata", rdata[u], e.rdata);
                    check("resp_err", err[u], e.err);
                end
            end else begin
                check("idle_rdata_err", {rdata[u], err[u]}, 0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int u, input int idx, input logic [31:0] d);
        dbg_we[u]    = 1'b1;
        dbg_addr[u]  = AWB'(idx);
        dbg_wdata[u] = d;
        @(posedge clk);
        #1;
        dbg_we[u] = 1'b0;
        model[u][idx] = d;
    endtask

    // One bus access; optionally a backdoor write in the same (grant) cycle.
    task automatic access(input int u, input logic w, input logic [33:0] a,
                          input logic [3:0] b, input logic [31:0] d, input logic push,
                          input logic bd, input int bd_idx, input logic [31:0] bd_d);
        int          waited;
        logic        er;
        int          idx;
        logic [31:0] rd;
        exp_t        e;
        req[u]   = 1'b1;
        we[u]    = w;
        addr[u]  = a;
        be[u]    = b;
        wdata[u] = d;
        size[u]  = 2'($urandom);
        waited   = 0;
        forever begin
            @(negedge clk);
            if (gnt[u] === 1'b1) break;
            waited++;
            if (waited > 40) begin
                checks++;
                errors++;
                $display("FAIL gnt_timeout: unit %0d no grant after %0d cycles, required %0d", u, waited, gw_of(u));
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $fatal(1, "grant timeout");
            end
        end
        check("gnt_wait", waited, gw_of(u));
        er  = (64'(a) >= 64'(4 * MW));
        idx = int'((64'(a) >> 2) % MW);
        rd  = (w || er) ? 32'h0 : model[u][idx];
        if (push) begin
            e.unit  = u;
            e.due   = cyc + longint'(lat_of(u));
            e.rdata = rd;
            e.err   = er;
            sbq.push_back(e);
        end
        if (bd) begin
            dbg_we[u]    = 1'b1;
            dbg_addr[u]  = AWB'(bd_idx);
            dbg_wdata[u] = bd_d;
            if (!(w && !er && idx == bd_idx)) model[u][bd_idx] = bd_d;
        end
        if (w && !er) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) model[u][idx][8*k +: 8] = d[8*k +: 8];
        end
        if (w) wr_m[u] = wr_m[u] + 16'd1;
        else   rd_m[u] = rd_m[u] + 16'd1;
        @(posedge clk);
        #1;
        req[u]    = 1'b0;
        dbg_we[u] = 1'b0;
    endtask

    task automatic check_counters(input int u);
        @(negedge clk);
        check("rd_count", rdc[u], rd_m[u]);
        check("wr_count", wrc[u], wr_m[u]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [33:0] a;
        logic [31:0] d;
        int          bi;
        int          drain;

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b1; we[u] = 1'b0; addr[u] = '0; be[u] = '0; wdata[u] = '0;
            size[u] = '0; dbg_we[u] = 1'b0; dbg_addr[u] = '0; dbg_wdata[u] = '0;
            rd_m[u] = '0; wr_m[u] = '0;
        end

        // Reset state: grant masked by reset even with a request present.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_gnt", gnt[u], 0);
            check("reset_rvalid", rvalid[u], 0);
            check("reset_rdata", rdata[u], 0);
            check("reset_err", err[u], 0);
            check("reset_rd_count", rdc[u], 0);
            check("reset_wr_count", wrc[u], 0);
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        req[0] = 1'b0;
        req[1] = 1'b0;

        // Preload both memories through the backdoor.
        for (int i = 0; i < MW; i++) begin
            bd_write(0, i, $urandom);
            bd_write(1, i, $urandom);
        end

        // Store then load, back to back.
        access(0, 1'b1, 34'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 0, 0);
        access(0, 1'b0, 34'h10, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);

        // Byte enables: 0x11223344 merged with 0xAABBCCDD under be=0101.
        bd_write(0, 4, 32'h11223344);
        access(0, 1'b1, 34'h10, 4'b0101, 32'hAABBCCDD, 1'b1, 1'b0, 0, 0);
        access(0, 1'b0, 34'h12, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);

        // Errors: high address bits, first word past the end, erroring store.
        access(0, 1'b0, 34'h1_0000_0000, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        access(0, 1'b0, 34'(4 * MW), 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        access(0, 1'b1, 34'(4 * MW) + 34'h10, 4'hF, 32'h55555555, 1'b1, 1'b0, 0, 0);
        access(0, 1'b0, 34'h10, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        idle(LAT0 + 1);
        check_counters(0);

        // Unit 1: wait states and four held back-to-back loads.
        access(1, 1'b0, 34'h8, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        for (int n = 0; n < 4; n++)
            access(1, 1'b0, 34'(4 * n), 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        idle(LAT1 + 1);
        check_counters(1);

        // Randomised traffic on both units, with occasional backdoor writes.
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 200; n++) begin
                case ($urandom % 8)
                    0:       a = {2'($urandom), 32'($urandom)};
                    1:       a = 34'(4 * MW) + 34'($urandom % 64);
                    default: a = 34'($urandom % (4 * MW));
                endcase
                bi = ($urandom % 2 == 0) ? int'((64'(a) >> 2) % MW) : int'($urandom % MW);
                access(u, 1'($urandom), a, 4'($urandom), $urandom, 1'b1,
                       ($urandom % 4 == 0), bi, $urandom);
                if ($urandom % 4 == 0) idle(1 + int'($urandom % 3));
            end
            idle(lat_of(u) + 1);
            check_counters(u);
        end

        // Reset with two grants still in flight: their responses never appear.
        idle(6);
        access(0, 1'b0, 34'h10, 4'h0, 32'h0, 1'b0, 1'b0, 0, 0);
        access(0, 1'b0, 34'h14, 4'h0, 32'h0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            rd_m[u] = '0;
            wr_m[u] = '0;
        end
        check_counters(0);
        check_counters(1);
        idle(6);
        access(0, 1'b0, 34'h10, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        access(0, 1'b0, 34'h14, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);

        // Store counter wrap; the last store collides with a backdoor write.
        for (int n = 0; n < 65536; n++)
            access(0, 1'b1, 34'h20, 4'hF, $urandom, 1'b1, 1'b0, 0, 0);
        d = $urandom;
        access(0, 1'b1, 34'h20, 4'hF, d, 1'b1, 1'b1, 8, ~d);
        access(0, 1'b0, 34'h20, 4'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        idle(LAT0 + 1);
        @(negedge clk);
        check("wr_count_wrap", wrc[0], 1);
        @(posedge clk);
        #1;
        check_counters(0);

        // Drain the scoreboard within a bounded time.
        drain = 0;
        while (sbq.size() != 0 && drain < 50) begin
            @(posedge clk);
            drain++;
        end
        check("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
